// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts rising edges of a selected ring oscillator over a clk gate window.
// Define RO_FREQ_METER_CONT_EN for continuous back-to-back measurements.
module ro_freq_meter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] osc_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   sync1_q, sync2_q;
    logic                hist_q;
    logic                sel_sync, rise, ch_ok;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   win_q, win_d;
    logic [1:0]          settle_q, settle_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic                res_ovf_q, res_ovf_d;

    // ch_q is only ever loaded with an in-range index
    assign sel_sync = sync2_q[ch_q];
    assign rise     = sel_sync & ~hist_q;
    assign ch_ok    = (int'(ch_sel) < NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= 1'b0;
            ch_q      <= '0;
            gate_q    <= '0;
            win_q     <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= osc_in;
            sync2_q   <= sync1_q;
            hist_q    <= sel_sync;
            ch_q      <= ch_d;
            gate_q    <= gate_d;
            win_q     <= win_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && ena) state_d = SETTLE;
            end
            SETTLE: begin
                if (!ena) state_d = IDLE;
                else if (settle_q == 2'd2)
                    state_d = (gate_q == '0) ? DONE : GATE;
            end
            GATE: begin
                if (!ena) state_d = IDLE;
                else if (win_q == GATE_W'(1)) state_d = DONE;
            end
            DONE: begin
`ifdef RO_FREQ_METER_CONT_EN
                state_d = (start && ena) ? SETTLE : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_d      = ch_q;
        gate_d    = gate_q;
        win_d     = win_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start && ena) begin
                    ch_d     = ch_ok ? ch_sel : '0;
                    gate_d   = gate_cycles;
                    settle_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 2'd1;
                win_d    = gate_q;
            end
            GATE: begin
                win_d = win_q - GATE_W'(1);
                if (rise) begin
                    if (cnt_q == '1) ovf_d = 1'b1;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                settle_d = '0;
                cnt_d    = '0;
                ovf_d    = 1'b0;
            end
            default: ;
        endcase
        // result lands on entry to DONE, including the final window cycle
        if (state_q != DONE && state_d == DONE) begin
            res_cnt_d = cnt_d;
            res_ovf_d = ovf_d;
        end
    end

    always_comb begin
        busy = (state_q == SETTLE) || (state_q == GATE);
        done = (state_q == DONE);
    end

    assign count    = res_cnt_q;
    assign overflow = res_ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: scoreboard bench for ro_freq_meter.
// A CNT_W=4 copy shares stimulus for the saturation case.
module tb_ro_freq_meter;

    logic        clk, rst_n, ena, start;
    logic [2:0]  osc;
    logic [1:0]  ch_sel;
    logic [15:0] gate;
    logic        busy, done, ovf;
    logic [15:0] cnt;
    logic        s_busy, s_done, s_ovf;
    logic [3:0]  s_cnt;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int per[3];
    int ph[3];

    typedef struct {
        int ecnt; bit eovf; int ecyc;
        bit sat; int scnt; bit sovf;
    } exp_t;
    exp_t q[$];

    ro_freq_meter #(.NUM_CH(3), .CNT_W(16), .GATE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc),
        .ch_sel(ch_sel), .gate_cycles(gate), .start(start),
        .busy(busy), .done(done), .count(cnt), .overflow(ovf)
    );

    ro_freq_meter #(.NUM_CH(3), .CNT_W(4), .GATE_W(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc),
        .ch_sel(ch_sel), .gate_cycles(gate), .start(start),
        .busy(s_busy), .done(s_done), .count(s_cnt), .overflow(s_ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // oscillators toggle 2ns after the clk edge, square waves of period per[i]
    initial begin
        osc = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (per[i] > 0) begin
                    ph[i] = (ph[i] + 1) % per[i];
                    osc[i] = (ph[i] < per[i] / 2);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("count", cnt, e.ecnt);
                chk("overflow", ovf, e.eovf);
                chk("done_cycle", cyc, e.ecyc);
                chk("busy_in_done", busy, 0);
                if (e.sat) begin
                    chk("sat_done", s_done, 1);
                    chk("sat_count", s_cnt, e.scnt);
                    chk("sat_overflow", s_ovf, e.sovf);
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input int ch, input int g, input int ecnt, input bit eovf,
                       input bit sat, input int scnt, input bit sovf);
        exp_t e;
        @(negedge clk);
        ch_sel = 2'(ch);
        gate   = 16'(g);
        start  = 1;
        e = '{ecnt, eovf, cyc + 4 + g, sat, scnt, sovf};
        q.push_back(e);
        @(negedge clk);
        start  = 0;
        ch_sel = 2'd2;
        gate   = 16'd7;
        chk("busy_on", busy, 1);
        drain(g + 50);
    endtask

    initial begin
        int c0;
        exp_t e;
        rst_n = 0; ena = 1; start = 0; ch_sel = 0; gate = 0;
        per[0] = 4; per[1] = 10; per[2] = 20;
        ph[0] = 0; ph[1] = 0; ph[2] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        repeat (4) @(negedge clk);

        run(1, 100, 10, 0, 0, 0, 0);
        run(0, 200, 50, 0, 0, 0, 0);
        run(2, 200, 10, 0, 0, 0, 0);
        run(0, 100, 25, 0, 1, 15, 1);

        @(negedge clk);
        ch_sel = 0; gate = 100; start = 1;
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count", cnt, 0);
        chk("arst_sat_count", s_cnt, 0);
        chk("arst_sat_ovf", s_ovf, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("arst_idle", busy, 0);

        run(3, 40, 10, 0, 0, 0, 0);

        @(negedge clk);
        ch_sel = 1; gate = 100; start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        ena = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        ena = 1;
        repeat (120) @(negedge clk);
        chk("abort_count_held", cnt, 10);
        chk("abort_ovf_held", ovf, 0);

        run(1, 0, 0, 0, 0, 0, 0);

`ifdef RO_FREQ_METER_CONT_EN
        @(negedge clk);
        ch_sel = 1; gate = 20; start = 1;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            e = '{2, 0, c0 + 24 * k, 0, 0, 0};
            q.push_back(e);
        end
        while (cyc < c0 + 30) @(negedge clk);
        chk("cont_busy", busy, 1);
        while (cyc < c0 + 50) @(negedge clk);
        start = 0;
        drain(60);
        chk("cont_stop_idle", busy, 0);
        repeat (30) @(negedge clk);
        chk("cont_stays_idle", busy, 0);
`else
        @(negedge clk);
        ch_sel = 1; gate = 10; start = 1;
        c0 = cyc;
        e = '{1, 0, c0 + 14, 0, 0, 0};
        q.push_back(e);
        e = '{1, 0, c0 + 29, 0, 0, 0};
        q.push_back(e);
        while (cyc < c0 + 15) @(negedge clk);
        chk("b2b_idle_gap", busy, 0);
        @(negedge clk);
        start = 0;
        drain(60);
        repeat (20) @(negedge clk);
        chk("b2b_stays_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
